// File: rtl/matrix_serializer_pkg.sv
// matrix_serializer_pkg: shared state encoding, frame constants and the 2-bit-per-step CRC-8 helper.
package matrix_serializer_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, HDR, BODY, CRC} state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hD5;
    localparam int         HDR_DIBITS = 12;
    localparam logic [7:0] CRC_POLY   = 8'h07;

    function automatic logic [7:0] crc8_step2(input logic [7:0] crc, input logic [1:0] d);
        logic [7:0] c;
        c = crc;
        for (int i = 1; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? CRC_POLY : 8'h00);
        return c;
    endfunction

endpackage

// File: rtl/matrix_store.sv
// matrix_store: simple dual-port element RAM, one write port and a 1-cycle registered read port.
module matrix_store #(
    parameter int ELEM_W = 8,
    parameter int DEPTH  = 2048,
    localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic              inter_refclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ELEM_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [ELEM_W-1:0] rdata
);

    logic [ELEM_W-1:0] mem [DEPTH];

    always_ff @(posedge inter_refclk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/matrix_serializer.sv
// matrix_serializer: loads randomly-ordered matrix elements, then streams a framed MSB-first dibit frame.
// Optional CRC-8 trailer is compiled in with MATRIX_SERIALIZER_CRC_EN.
module matrix_serializer
    import matrix_serializer_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter int MAX_ROWS = 32,
    parameter int MAX_COLS = 32,
    parameter int NUM_MAT  = 2,
    localparam int DIM_W   = 8,
    localparam int MAT_W   = NUM_MAT > 1 ? $clog2(NUM_MAT) : 1,
    localparam int ROW_W   = MAX_ROWS > 1 ? $clog2(MAX_ROWS) : 1,
    localparam int COL_W   = MAX_COLS > 1 ? $clog2(MAX_COLS) : 1
) (
    input  logic              inter_refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MAT_W-1:0]  in_mat,
    input  logic [ROW_W-1:0]  in_row,
    input  logic [COL_W-1:0]  in_col,
    input  logic [ELEM_W-1:0] in_data,
    output logic [1:0]        dibit_out,
    output logic              dibit_valid,
    input  logic              dibit_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              err_cfg,
    output logic              err_oob
);

    localparam int TOTAL  = NUM_MAT * MAX_ROWS * MAX_COLS;
    localparam int ADDR_W = TOTAL > 1 ? $clog2(TOTAL) : 1;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int SUB_W  = $clog2(ELEM_W / 2 > HDR_DIBITS ? ELEM_W / 2 : HDR_DIBITS);
    localparam int SR_W   = ELEM_W > 24 ? ELEM_W : 24;
    localparam logic [SUB_W-1:0] HDR_LAST  = SUB_W'(HDR_DIBITS - 1);
    localparam logic [SUB_W-1:0] ELEM_LAST = SUB_W'(ELEM_W / 2 - 1);
    localparam logic [SUB_W-1:0] CRC_LAST  = SUB_W'(3);

    function automatic logic [ADDR_W-1:0] addr_of(input logic [MAT_W-1:0] m, input logic [DIM_W-1:0] r,
                                                  input logic [DIM_W-1:0] c);
        return ADDR_W'(m) * ADDR_W'(MAX_ROWS * MAX_COLS) + ADDR_W'(r) * ADDR_W'(MAX_COLS) + ADDR_W'(c);
    endfunction

    state_t            state, state_nx;
    logic [DIM_W-1:0]  rows_q, cols_q;
    logic [TOTAL-1:0]  bitmap;
    logic [CNT_W-1:0]  cnt, target;
    logic [SUB_W-1:0]  sub;
    logic [SR_W-1:0]   sr;
    logic [MAT_W-1:0]  p_mat, pn_mat;
    logic [DIM_W-1:0]  p_row, p_col, pn_row, pn_col;
    logic [ADDR_W-1:0] wa, ra;
    logic [ELEM_W-1:0] rdata;
    logic cfg_ok, wr, oob, wr_ok, is_new, xfer, fld_end, load, last_elem, col_wrap, row_wrap;
`ifdef MATRIX_SERIALIZER_CRC_EN
    logic [7:0] crc;
`endif

    assign cfg_ok      = cfg_rows != '0 && cfg_rows <= DIM_W'(MAX_ROWS) && cfg_cols != '0 && cfg_cols <= DIM_W'(MAX_COLS);
    assign in_ready    = state == LOAD;
    assign busy        = state != IDLE;
    assign dibit_valid = state inside {HDR, BODY, CRC};
    assign dibit_out   = dibit_valid ? sr[SR_W-1 -: 2] : 2'b00;
    assign wr          = in_valid && in_ready;
    assign oob         = 32'(in_mat) >= NUM_MAT || DIM_W'(in_row) >= rows_q || DIM_W'(in_col) >= cols_q;
    assign wr_ok       = wr && !oob;
    assign wa          = addr_of(in_mat, DIM_W'(in_row), DIM_W'(in_col));
    assign is_new      = !bitmap[wa];
    assign target      = CNT_W'(NUM_MAT) * CNT_W'(rows_q) * CNT_W'(cols_q);
    assign xfer        = dibit_valid && dibit_ready;
    assign fld_end     = xfer && sub == (state == HDR ? HDR_LAST : state == BODY ? ELEM_LAST : CRC_LAST);
    assign load        = fld_end && (state == HDR || state == BODY);
    // cnt counts down remaining elements while in BODY
    assign last_elem   = fld_end && state == BODY && cnt == CNT_W'(1);

    // read address follows the pointer's next value so the next element is ready on every load
    assign col_wrap = p_col == cols_q - DIM_W'(1);
    assign row_wrap = p_row == rows_q - DIM_W'(1);
    assign pn_col   = load ? (col_wrap ? '0 : p_col + DIM_W'(1)) : p_col;
    assign pn_row   = load && col_wrap ? (row_wrap ? '0 : p_row + DIM_W'(1)) : p_row;
    assign pn_mat   = load && col_wrap && row_wrap ? p_mat + MAT_W'(1) : p_mat;
    assign ra       = addr_of(pn_mat, pn_row, pn_col);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cfg_valid && cfg_ok) state_nx = LOAD;
            LOAD: if (wr_ok && is_new && cnt + CNT_W'(1) == target) state_nx = HDR;
            HDR:  if (fld_end) state_nx = BODY;
`ifdef MATRIX_SERIALIZER_CRC_EN
            BODY: if (last_elem) state_nx = CRC;
            CRC:  if (fld_end) state_nx = IDLE;
`else
            BODY: if (last_elem) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge inter_refclk) state <= rst ? IDLE : state_nx;

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            {err_cfg, err_oob, frame_done} <= '0;
            {rows_q, cols_q} <= '0;
            bitmap <= '0;
            cnt    <= '0;
            sub    <= '0;
            sr     <= '0;
            {p_mat, p_row, p_col} <= '0;
`ifdef MATRIX_SERIALIZER_CRC_EN
            crc    <= '0;
`endif
        end else begin
            err_cfg    <= state == IDLE && cfg_valid && !cfg_ok;
            err_oob    <= wr && oob;
            frame_done <= state != IDLE && state_nx == IDLE;
            if (state == IDLE && cfg_valid && cfg_ok) begin
                rows_q <= cfg_rows;
                cols_q <= cfg_cols;
            end
            if (wr_ok) begin
                bitmap[wa] <= 1'b1;
                cnt        <= cnt + CNT_W'(is_new);
            end
            {p_mat, p_row, p_col} <= {pn_mat, pn_row, pn_col};
            if (xfer) begin
                sr  <= sr << 2;
                sub <= sub + SUB_W'(1);
            end
            if (load) begin
                sr  <= SR_W'(rdata) << (SR_W - ELEM_W);
                sub <= '0;
            end
            if (state == BODY && fld_end) cnt <= cnt - CNT_W'(1);
            if (state == LOAD && state_nx == HDR) begin
                sr  <= SR_W'({SYNC_BYTE, rows_q, cols_q}) << (SR_W - 24);
                sub <= '0;
            end
`ifdef MATRIX_SERIALIZER_CRC_EN
            if (xfer) crc <= crc8_step2(crc, dibit_out);
            if (state == LOAD) crc <= '0;
            if (last_elem) sr <= SR_W'(crc8_step2(crc, dibit_out)) << (SR_W - 8);
`endif
            if (state_nx == IDLE) begin
                bitmap <= '0;
                cnt    <= '0;
                {p_mat, p_row, p_col} <= '0;
            end
        end
    end

    matrix_store #(.ELEM_W(ELEM_W), .DEPTH(TOTAL)) u_store (
        .inter_refclk (inter_refclk),
        .we           (wr_ok),
        .waddr        (wa),
        .wdata        (in_data),
        .raddr        (ra),
        .rdata        (rdata)
    );

endmodule
